// File: rtl/sipo_deser_if.sv
// Bundle for the sipo_deser serial input, parallel output handshake and status flags.
// The slave modport is the deserializer; the master modport is whoever drives the link and consumes words.
interface sipo_deser_if #(
    parameter int unsigned WIDTH = 4
);
    logic             sin;
    logic             sin_en;
    logic             start;
    logic             dout_ready;
    logic             clr;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             busy;
    logic             frame_err;
    logic             overrun;

    modport master (
        output sin, sin_en, start, dout_ready, clr,
        input  dout, dout_valid, busy, frame_err, overrun
    );

    modport slave (
        input  sin, sin_en, start, dout_ready, clr,
        output dout, dout_valid, busy, frame_err, overrun
    );
endinterface

// File: rtl/sipo_deser.sv
// LSB-first serial-in parallel-out deserializer with a valid/ready output holding register,
// framing-error pulse on mid-word restart and sticky overrun when a completed word is dropped.
module sipo_deser #(
    parameter int unsigned WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    sipo_deser_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    // Only sr[WIDTH-1:1] is kept: sr[0] is shifted out before it could ever reach a completed word.
    logic [WIDTH-2:0] sr_q;
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q;
    logic             frame_err_q;
    logic             overrun_q;

    logic [WIDTH-1:0] word_d;
    logic             take_d;
    logic             last_d;
    logic             abort_d;
    logic             drop_d;

    // Decode of the current bit against the FSM state.
    always_comb begin
        word_d  = {bus.sin, sr_q};
        take_d  = bus.sin_en && (bus.start || (state_q == SHIFT));
        last_d  = bus.sin_en && !bus.start && (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
        abort_d = bus.sin_en && bus.start && (state_q == SHIFT);
        drop_d  = last_d && dout_valid_q && !bus.dout_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sr_q         <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_err_q <= abort_d;

            if (take_d) begin
                sr_q <= word_d[WIDTH-1:1];
            end

            if (state_q == IDLE) begin
                if (bus.sin_en && bus.start) begin
                    state_q <= SHIFT;
                    cnt_q   <= CW'(1);
                end
            end else if (bus.sin_en) begin
                if (bus.start) begin
                    cnt_q <= CW'(1);
                end else if (cnt_q == CW'(WIDTH - 1)) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end

            // A completing word may load into a slot that is being emptied on this same edge.
            if (last_d) begin
                if (!dout_valid_q || bus.dout_ready) begin
                    dout_q       <= word_d;
                    dout_valid_q <= 1'b1;
                end
            end else if (dout_valid_q && bus.dout_ready) begin
                dout_valid_q <= 1'b0;
            end

            if (drop_d) begin
                overrun_q <= 1'b1;
            end else if (bus.clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = (state_q == SHIFT);
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: directed vector table, a reset-abort sequence,
// then randomized traffic checked against a bit-indexed word assembly model.
module tb_sipo_deser;
    localparam int unsigned W = 4;

    logic clk;
    logic rst;

    sipo_deser_if #(.WIDTH(W)) bus ();

    sipo_deser #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total;
    int n_pass;

    typedef struct {
        logic         s, en, st, rdy, cl;
        logic [W-1:0] dout;
        logic         dv, busy, fe, ov;
        string        tag;
    } vec_t;

    vec_t vecs[$];

    // Reference model: bits collected by position since the last start.
    int           m_n;
    logic [W-1:0] m_acc;
    logic [W-1:0] m_dout;
    logic         m_dv, m_fe, m_ov;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic model_reset();
        m_n = 0; m_acc = '0; m_dout = '0; m_dv = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    endtask

    task automatic model_edge(input logic s, input logic en, input logic st,
                              input logic rdy, input logic cl);
        bit           done;
        bit           newov;
        logic [W-1:0] word;
        done = 1'b0;
        word = '0;
        m_fe = 1'b0;
        if (en) begin
            if (st) begin
                m_fe     = (m_n > 0);
                m_acc    = '0;
                m_acc[0] = s;
                m_n      = 1;
            end else if (m_n > 0) begin
                m_acc[m_n] = s;
                m_n++;
                if (m_n == W) begin
                    done = 1'b1;
                    word = m_acc;
                    m_n  = 0;
                end
            end
        end
        newov = done && m_dv && !rdy;
        if (done && !newov) begin
            m_dout = word;
            m_dv   = 1'b1;
        end else if (!done && m_dv && rdy) begin
            m_dv = 1'b0;
        end
        if (newov) m_ov = 1'b1;
        else if (cl) m_ov = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic step(input logic s, input logic en, input logic st,
                        input logic rdy, input logic cl);
        bus.sin = s; bus.sin_en = en; bus.start = st; bus.dout_ready = rdy; bus.clr = cl;
        model_edge(s, en, st, rdy, cl);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".dout"},       int'(bus.dout),       int'(m_dout));
        chk({tag, ".dout_valid"}, int'(bus.dout_valid), int'(m_dv));
        chk({tag, ".busy"},       int'(bus.busy),       int'(m_n > 0));
        chk({tag, ".frame_err"},  int'(bus.frame_err),  int'(m_fe));
        chk({tag, ".overrun"},    int'(bus.overrun),    int'(m_ov));
    endtask

    function automatic void add(input string tag, input logic s, input logic en, input logic st,
                                input logic rdy, input logic cl, input logic [W-1:0] dout,
                                input logic dv, input logic busy, input logic fe, input logic ov);
        vec_t v;
        v.tag = tag; v.s = s; v.en = en; v.st = st; v.rdy = rdy; v.cl = cl;
        v.dout = dout; v.dv = dv; v.busy = busy; v.fe = fe; v.ov = ov;
        vecs.push_back(v);
    endfunction

    initial begin
        //   tag        s  en st rdy cl  dout  dv busy fe ov
        add("basic",    1, 1, 1, 1, 0, 4'h0, 0, 1, 0, 0);
        add("basic",    1, 1, 0, 1, 0, 4'h0, 0, 1, 0, 0);
        add("basic",    0, 1, 0, 1, 0, 4'h0, 0, 1, 0, 0);
        add("basic",    1, 1, 0, 1, 0, 4'hB, 1, 0, 0, 0);
        add("basic",    0, 0, 0, 1, 0, 4'hB, 0, 0, 0, 0);
        add("gaps",     1, 1, 1, 1, 0, 4'hB, 0, 1, 0, 0);
        add("gaps",     0, 0, 1, 1, 0, 4'hB, 0, 1, 0, 0);
        add("gaps",     1, 0, 0, 1, 0, 4'hB, 0, 1, 0, 0);
        add("gaps",     1, 1, 0, 1, 0, 4'hB, 0, 1, 0, 0);
        add("gaps",     1, 0, 0, 1, 0, 4'hB, 0, 1, 0, 0);
        add("gaps",     0, 0, 1, 1, 0, 4'hB, 0, 1, 0, 0);
        add("gaps",     0, 1, 0, 1, 0, 4'hB, 0, 1, 0, 0);
        add("gaps",     0, 0, 0, 1, 0, 4'hB, 0, 1, 0, 0);
        add("gaps",     1, 0, 0, 1, 0, 4'hB, 0, 1, 0, 0);
        add("gaps",     1, 1, 0, 1, 0, 4'hB, 1, 0, 0, 0);
        add("gaps",     0, 0, 0, 1, 0, 4'hB, 0, 0, 0, 0);
        add("nostart",  1, 1, 0, 1, 0, 4'hB, 0, 0, 0, 0);
        add("nostart",  0, 1, 0, 1, 0, 4'hB, 0, 0, 0, 0);
        add("restart",  1, 1, 1, 1, 0, 4'hB, 0, 1, 0, 0);
        add("restart",  0, 1, 0, 1, 0, 4'hB, 0, 1, 0, 0);
        add("restart",  0, 1, 1, 1, 0, 4'hB, 0, 1, 1, 0);
        add("restart",  1, 1, 0, 1, 0, 4'hB, 0, 1, 0, 0);
        add("restart",  1, 1, 0, 1, 0, 4'hB, 0, 1, 0, 0);
        add("restart",  1, 1, 0, 1, 0, 4'hE, 1, 0, 0, 0);
        add("hold",     0, 0, 0, 0, 0, 4'hE, 1, 0, 0, 0);
        add("hold",     0, 0, 0, 1, 0, 4'hE, 0, 0, 0, 0);
        add("overrun",  1, 1, 1, 0, 0, 4'hE, 0, 1, 0, 0);
        add("overrun",  1, 1, 0, 0, 0, 4'hE, 0, 1, 0, 0);
        add("overrun",  0, 1, 0, 0, 0, 4'hE, 0, 1, 0, 0);
        add("overrun",  0, 1, 0, 0, 0, 4'h3, 1, 0, 0, 0);
        add("overrun",  1, 1, 1, 0, 0, 4'h3, 1, 1, 0, 0);
        add("overrun",  0, 1, 0, 0, 0, 4'h3, 1, 1, 0, 0);
        add("overrun",  1, 1, 0, 0, 0, 4'h3, 1, 1, 0, 0);
        add("overrun",  0, 1, 0, 0, 0, 4'h3, 1, 0, 0, 1);
        add("overrun",  0, 0, 0, 1, 0, 4'h3, 0, 0, 0, 1);
        add("overrun",  0, 0, 0, 0, 1, 4'h3, 0, 0, 0, 0);
        add("simul",    0, 1, 1, 0, 0, 4'h3, 0, 1, 0, 0);
        add("simul",    1, 1, 0, 0, 0, 4'h3, 0, 1, 0, 0);
        add("simul",    0, 1, 0, 0, 0, 4'h3, 0, 1, 0, 0);
        add("simul",    1, 1, 0, 0, 0, 4'hA, 1, 0, 0, 0);
        add("simul",    0, 1, 1, 0, 0, 4'hA, 1, 1, 0, 0);
        add("simul",    1, 1, 0, 0, 0, 4'hA, 1, 1, 0, 0);
        add("simul",    1, 1, 0, 0, 0, 4'hA, 1, 1, 0, 0);
        add("simul",    0, 1, 0, 1, 0, 4'h6, 1, 0, 0, 0);
        add("simul",    0, 0, 0, 1, 0, 4'h6, 0, 0, 0, 0);
        add("clrset",   1, 1, 1, 0, 0, 4'h6, 0, 1, 0, 0);
        add("clrset",   1, 1, 0, 0, 0, 4'h6, 0, 1, 0, 0);
        add("clrset",   1, 1, 0, 0, 0, 4'h6, 0, 1, 0, 0);
        add("clrset",   0, 1, 0, 0, 0, 4'h7, 1, 0, 0, 0);
        add("clrset",   1, 1, 1, 0, 0, 4'h7, 1, 1, 0, 0);
        add("clrset",   1, 1, 0, 0, 0, 4'h7, 1, 1, 0, 0);
        add("clrset",   1, 1, 0, 0, 0, 4'h7, 1, 1, 0, 0);
        add("clrset",   1, 1, 0, 0, 1, 4'h7, 1, 0, 0, 1);
        add("clrset",   0, 0, 0, 1, 1, 4'h7, 0, 0, 0, 0);

        n_total = 0;
        n_pass  = 0;
        rst = 1'b1;
        bus.sin = 1'b0; bus.sin_en = 1'b0; bus.start = 1'b0; bus.dout_ready = 1'b0; bus.clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.dout",       int'(bus.dout),       0);
        chk("reset.dout_valid", int'(bus.dout_valid), 0);
        chk("reset.busy",       int'(bus.busy),       0);
        chk("reset.frame_err",  int'(bus.frame_err),  0);
        chk("reset.overrun",    int'(bus.overrun),    0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].s, vecs[i].en, vecs[i].st, vecs[i].rdy, vecs[i].cl);
            chk({vecs[i].tag, ".dout"},       int'(bus.dout),       int'(vecs[i].dout));
            chk({vecs[i].tag, ".dout_valid"}, int'(bus.dout_valid), int'(vecs[i].dv));
            chk({vecs[i].tag, ".busy"},       int'(bus.busy),       int'(vecs[i].busy));
            chk({vecs[i].tag, ".frame_err"},  int'(bus.frame_err),  int'(vecs[i].fe));
            chk({vecs[i].tag, ".overrun"},    int'(bus.overrun),    int'(vecs[i].ov));
        end

        // Reset mid-word with a word still held and overrun set: everything clears at once.
        step(0, 1, 1, 0, 0); step(0, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0);
        chk("pre_rst.dout",    int'(bus.dout),    4'hC);
        chk("pre_rst.overrun", int'(bus.overrun), 1);
        step(1, 1, 1, 0, 0); step(0, 1, 0, 0, 0);
        chk("pre_rst.busy",    int'(bus.busy),    1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid.dout",       int'(bus.dout),       0);
        chk("rst_mid.dout_valid", int'(bus.dout_valid), 0);
        chk("rst_mid.busy",       int'(bus.busy),       0);
        chk("rst_mid.frame_err",  int'(bus.frame_err),  0);
        chk("rst_mid.overrun",    int'(bus.overrun),    0);
        model_reset();
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        step(1, 1, 1, 1, 0); chk("post_rst.frame_err", int'(bus.frame_err), 0);
        step(0, 1, 0, 1, 0); chk("post_rst.frame_err", int'(bus.frame_err), 0);
        step(0, 1, 0, 1, 0); chk("post_rst.frame_err", int'(bus.frame_err), 0);
        step(1, 1, 0, 1, 0);
        chk("post_rst.dout",       int'(bus.dout),       4'h9);
        chk("post_rst.dout_valid", int'(bus.dout_valid), 1);
        chk("post_rst.frame_err",  int'(bus.frame_err),  0);
        chk_model("post_rst");

        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 99) < 12),
                 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 19) == 0));
            chk_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sipo_deser.md
# sipo_deser

Serial-in parallel-out deserializer: the receive end of the LSB-first serial link driven by the team's parallel-in serial-out shifter. It samples one bit per enabled clock, assembles WIDTH-bit words, and presents each word on a valid/ready holding register. It flags framing errors on a mid-word restart and overruns when the consumer stalls. It sits between the serial link pins or retiming flops and any parallel consumer, such as a register file or FIFO.

## Interface
- WIDTH, 4, bits per word; legal range 2..16.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- sin  input  1  serial data bit, LSB first.
- sin_en  input  1  sin is sampled on this edge only when high.
- start  input  1  qualified by sin_en; marks the current sin bit as bit 0 of a new word.
- dout_ready  input  1  consumer accepts dout this cycle when high with dout_valid.
- clr  input  1  clears the overrun flag.
- dout  output  WIDTH  last completed word.
- dout_valid  output  1  dout holds an unconsumed word.
- busy  output  1  a word is partially assembled.
- frame_err  output  1  one-cycle pulse: a partial word was aborted by start.
- overrun  output  1  sticky: a completed word was dropped.

## Operation
- Internal state: shift register sr[WIDTH-1:0], bit counter cnt (0..WIDTH-1), FSM {IDLE, SHIFT}.
- Assembly is LSB first. On each accepted bit, sr <= {sin, sr[WIDTH-1:1]}. After WIDTH bits, sr[0] is the first bit received.
- IDLE:
  - sin_en=0 or start=0: no action. Bits without start are discarded.
  - sin_en=1 and start=1: shift in the bit, cnt<=1, go to SHIFT.
- SHIFT:
  - sin_en=0: hold all state.
  - sin_en=1, start=0, cnt<WIDTH-1: shift in the bit, cnt<=cnt+1.
  - sin_en=1, start=0, cnt==WIDTH-1: this is the last bit. The completed word is {sin, sr[WIDTH-1:1]}. Go to IDLE, cnt<=0.
  - sin_en=1, start=1: the partial word is discarded and frame_err pulses. sr<={sin, sr[WIDTH-1:1]} (stale upper bits are don't-care), cnt<=1, stay in SHIFT.
- busy = (state==SHIFT).
- Output register, evaluated on each edge:
  - A word completes and the slot is free (dout_valid=0, or dout_ready=1 this cycle): dout<=word, dout_valid<=1.
  - A word completes while dout_valid=1 and dout_ready=0: the word is dropped, dout is unchanged, overrun<=1.
  - No completion and dout_valid & dout_ready: dout_valid<=0. dout keeps its last value.
- overrun clears on clr=1. If clr and a new overrun occur on the same edge, set wins.
- No arithmetic beyond cnt increment. cnt width is $clog2(WIDTH). cnt never wraps past WIDTH-1.

## Timing
- Reset (async, immediate):
  - state=IDLE, sr=0, cnt=0.
  - dout=0, dout_valid=0, busy=0, frame_err=0, overrun=0.
- Reset asserted mid-word aborts the word with no frame_err. The first bit after reset release must carry start.
- Latency: dout/dout_valid update on the same edge that samples bit WIDTH-1, so they are visible the cycle after the last bit is presented.
- Back-to-back: bit 0 of the next word may be presented on the cycle immediately after the last bit. One word per WIDTH enabled cycles is sustained with no gap.
- The handshake transfers on an edge where dout_valid & dout_ready. dout is stable while dout_valid=1 and dout_ready=0.
- frame_err is high for exactly the cycle after the aborting edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Basic word (WIDTH=4, dout_ready=1): start with bits 1,1,0,1 on consecutive enabled cycles -> dout=4'hB and dout_valid=1 for one cycle after the 4th edge; busy high for 3 cycles.
- Enable gaps: same bits with sin_en low for 2 cycles between each bit -> dout=4'hB; no state change during gaps. Bits presented with start=0 while IDLE -> no busy, no output.
- Restart: start, bits 1,0, then start with bits 0,1,1,1 -> frame_err pulses once; dout=4'hE; overrun=0.
- Overrun: dout_ready=0; words 4'h3 then 4'h5 -> dout stays 4'h3, overrun=1. Then dout_ready=1 -> dout_valid falls. Then clr -> overrun=0.
- Simultaneous accept and complete: dout_valid=1 with 4'hA, dout_ready=1 on the edge completing 4'h6 -> dout=4'h6, dout_valid remains 1, overrun=0.
- Reset mid-word: rst pulse after 2 bits -> all outputs 0 immediately. A following full word 4'h9 -> dout=4'h9 with no frame_err.
